// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader: boot sequencer that freezes, identifies, mode-sets, optionally ucode-loads and unfreezes every core.
// Define BP_CFG_LOADER_UCODE_EN to include the CCE ucode load phase (UC_FETCH/UC_SEND).
module bp_cfg_loader #(
    parameter int num_core_p        = 1,
    parameter int cfg_core_width_p  = 8,
    parameter int cfg_addr_width_p  = 16,
    parameter int cfg_data_width_p  = 64,
    parameter int cce_pc_width_p    = 8,
    parameter int cce_instr_width_p = 48,
    parameter int ucode_els_p       = 256
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         start_i,
    input  logic                         cce_mode_i,
    output logic                         cfg_v_o,
    input  logic                         cfg_ready_i,
    output logic [cfg_core_width_p-1:0]  cfg_core_o,
    output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
    output logic [cfg_data_width_p-1:0]  cfg_data_o,
    output logic                         ucode_v_o,
    output logic [cce_pc_width_p-1:0]    ucode_addr_o,
    input  logic [cce_instr_width_p-1:0] ucode_data_i,
    output logic                         busy_o,
    output logic                         done_o
);
    localparam int CW = $clog2(num_core_p) + 1;

    typedef enum logic [2:0] {IDLE, FREEZE, CORE_ID, MODE, UC_FETCH, UC_SEND, UNFREEZE, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] core_q, core_d;
    logic          mode_q, mode_d;
    logic          xfer, last_core;

    assign xfer      = cfg_v_o & cfg_ready_i;
    assign last_core = core_q == CW'(num_core_p - 1);

`ifdef BP_CFG_LOADER_UCODE_EN
    localparam int UW = cce_pc_width_p + 1;
    logic [UW-1:0]                uc_q, uc_d;
    logic                         have_q, have_d;
    logic [cce_instr_width_p-1:0] ucd_q, ucd_d;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            uc_q   <= '0;
            have_q <= 1'b0;
            ucd_q  <= '0;
        end else begin
            uc_q   <= uc_d;
            have_q <= have_d;
            ucd_q  <= ucd_d;
        end
    end
`else
    localparam int unused_els = ucode_els_p;
    logic unused_ucode;
    assign unused_ucode = ^ucode_data_i;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            core_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            core_q  <= core_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        core_d  = core_q;
        mode_d  = mode_q;
`ifdef BP_CFG_LOADER_UCODE_EN
        uc_d    = uc_q;
        have_d  = have_q;
        ucd_d   = ucd_q;
`endif
        case (state_q)
            IDLE, DONE: if (start_i) begin
                state_d = FREEZE;
                core_d  = '0;
                mode_d  = cce_mode_i;
            end
            FREEZE:  if (xfer) state_d = CORE_ID;
            CORE_ID: if (xfer) state_d = MODE;
            MODE: if (xfer) begin
`ifdef BP_CFG_LOADER_UCODE_EN
                state_d = UC_FETCH;
                uc_d    = '0;
`else
                state_d = last_core ? UNFREEZE : FREEZE;
                core_d  = last_core ? '0 : core_q + 1'b1;
`endif
            end
`ifdef BP_CFG_LOADER_UCODE_EN
            UC_FETCH: begin
                state_d = UC_SEND;
                have_d  = 1'b0;
            end
            // First UC_SEND cycle only captures the ROM word; the write is offered from the register after.
            UC_SEND: if (!have_q) begin
                have_d = 1'b1;
                ucd_d  = ucode_data_i;
            end else if (xfer) begin
                if (uc_q == UW'(ucode_els_p - 1)) begin
                    state_d = last_core ? UNFREEZE : FREEZE;
                    core_d  = last_core ? '0 : core_q + 1'b1;
                end else begin
                    state_d = UC_FETCH;
                    uc_d    = uc_q + 1'b1;
                end
            end
`endif
            UNFREEZE: if (xfer) begin
                state_d = last_core ? DONE : UNFREEZE;
                core_d  = last_core ? '0 : core_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        cfg_v_o    = 1'b0;
        cfg_addr_o = '0;
        cfg_data_o = '0;
        case (state_q)
            FREEZE: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = cfg_addr_width_p'(1);
                cfg_data_o = cfg_data_width_p'(1);
            end
            CORE_ID: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = cfg_addr_width_p'(2);
                cfg_data_o = cfg_data_width_p'(core_q);
            end
            MODE: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = cfg_addr_width_p'(3);
                cfg_data_o = cfg_data_width_p'(mode_q);
            end
`ifdef BP_CFG_LOADER_UCODE_EN
            UC_SEND: begin
                cfg_v_o    = have_q;
                cfg_addr_o = have_q ? (cfg_addr_width_p'(16'h8000) | cfg_addr_width_p'(uc_q)) : '0;
                cfg_data_o = have_q ? cfg_data_width_p'(ucd_q) : '0;
            end
`endif
            UNFREEZE: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = cfg_addr_width_p'(1);
            end
            default: ;
        endcase
        cfg_core_o = cfg_v_o ? cfg_core_width_p'(core_q) : '0;
        busy_o     = state_q != IDLE && state_q != DONE;
        done_o     = state_q == DONE;
    end

`ifdef BP_CFG_LOADER_UCODE_EN
    assign ucode_v_o    = state_q == UC_FETCH;
    assign ucode_addr_o = uc_q[cce_pc_width_p-1:0];
`else
    assign ucode_v_o    = 1'b0;
    assign ucode_addr_o = '0;
`endif
endmodule

// File: tb/tb_bp_cfg_loader.sv
// tb_bp_cfg_loader: randomized scoreboard bench for bp_cfg_loader with 2 cores and 4 ucode words.
module tb_bp_cfg_loader;
    localparam int N  = 2;
    localparam int UE = 4;
`ifdef BP_CFG_LOADER_UCODE_EN
    localparam int UC = UE;
`else
    localparam int UC = 0;
`endif

    typedef struct {
        logic [7:0]  c;
        logic [15:0] a;
        logic [63:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        cfg_ready = 1'b1;
    logic        cfg_v, ucode_v, busy, done;
    logic [7:0]  core, ucode_addr;
    logic [15:0] addr;
    logic [63:0] data;
    logic [47:0] rom_q = '0;
    logic [47:0] rom_mem [256];

    wr_t  exp_q[$];
    wr_t  hp;
    logic hold = 1'b0;
    logic exp_done = 1'b0;
    logic sb_en = 1'b1;
    int   rdy_mode = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    bp_cfg_loader #(
        .num_core_p(N),
        .ucode_els_p(UE)
    ) dut (
        .clk_i(clk),
        .reset_n_i(rst_n),
        .start_i(start),
        .cce_mode_i(mode),
        .cfg_v_o(cfg_v),
        .cfg_ready_i(cfg_ready),
        .cfg_core_o(core),
        .cfg_addr_o(addr),
        .cfg_data_o(data),
        .ucode_v_o(ucode_v),
        .ucode_addr_o(ucode_addr),
        .ucode_data_i(rom_q),
        .busy_o(busy),
        .done_o(done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for the strobed address appears in the following cycle.
    always @(posedge clk) if (ucode_v) rom_q <= rom_mem[ucode_addr];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference order: all cores frozen/configured/loaded, then all unfrozen.
    task automatic push_run(logic m);
        for (int c = 0; c < N; c++) begin
            exp_q.push_back('{c[7:0], 16'h0001, 64'd1});
            exp_q.push_back('{c[7:0], 16'h0002, 64'(c)});
            exp_q.push_back('{c[7:0], 16'h0003, 64'(m)});
            for (int u = 0; u < UC; u++) exp_q.push_back('{c[7:0], 16'h8000 + 16'(u), 64'(rom_mem[u])});
        end
        for (int c = 0; c < N; c++) exp_q.push_back('{c[7:0], 16'h0001, 64'd0});
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        cfg_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom % 2) : 1'b0;
    end

    initial forever begin
        wr_t e;
        @(negedge clk);
        if (rst_n && sb_en) begin
            if (exp_done) begin
                chk("done_after_last", done, 1);
                exp_done = 1'b0;
            end
            if (hold) begin
                chk("hold_v", cfg_v, 1);
                chk("hold_core", core, hp.c);
                chk("hold_addr", addr, hp.a);
                chk("hold_data", data, hp.d);
            end
`ifndef BP_CFG_LOADER_UCODE_EN
            chk("ucode_v_off", ucode_v, 0);
`endif
            hold = cfg_v && !cfg_ready;
            if (hold) hp = '{core, addr, data};
            if (cfg_v && cfg_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got core %0h addr %0h data %0h, none required", core, addr, data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_core", core, e.c);
                    chk("wr_addr", addr, e.a);
                    chk("wr_data", data, e.d);
                    if (exp_q.size() == 0) exp_done = 1'b1;
                end
            end
        end
    end

    task automatic pulse_start(logic m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = ~m;
        @(negedge clk);
        chk("v_after_start", cfg_v, 1);
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
    endtask

    // kind: 0 plain, 1 extra start pulse mid-run, 2 three-cycle stall on the second write
    task automatic run(logic m, int kind);
        int k = 0;
        int saved = rdy_mode;
        push_run(m);
        pulse_start(m);
        if (kind == 2) begin
            rdy_mode = 0;
            @(posedge clk);
            #1 rdy_mode = 2;
            repeat (3) @(posedge clk);
            #1 rdy_mode = saved;
        end
        if (kind == 1) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            mode  = ~m;
            @(negedge clk);
            start = 1'b0;
        end
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("done_reached", done, 1);
        chk("busy_at_done", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) rom_mem[i] = 48'hA0 + 48'(i);
        repeat (3) @(negedge clk);
        chk("rst_v", cfg_v, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ucode_v", ucode_v, 0);
        chk("rst_core", core, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        run(1'b1, 0);
        run(1'b1, 2);
        for (int i = 0; i < 256; i++) rom_mem[i] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        rdy_mode = 1;
        repeat (3) run(1'($urandom % 2), 0);
        run(1'($urandom % 2), 1);

        push_run(1'b1);
        pulse_start(1'b1);
        k = 0;
        while (!(cfg_v && core == 8'd1 && addr == 16'h0002) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_c1_core_id", {core, addr}, {8'd1, 16'h0002});
        #1 rst_n = 1'b0;
        sb_en = 1'b0;
        #1;
        chk("rstmid_v", cfg_v, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_core", core, 0);
        chk("rstmid_addr", addr, 0);
        exp_q.delete();
        hold = 1'b0;
        exp_done = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        sb_en = 1'b1;
        @(negedge clk);
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);
        run(1'($urandom % 2), 0);
        rdy_mode = 0;
        run(1'b0, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
